// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: per-channel periodic or one-shot pulses, optional square wave (macro TICK_GEN_SQUARE_EN).
// Latency: tick_o/done_o/square_o are registered; a tick is visible one cycle after the edge where cnt matches divr.
// Backpressure: none; en_i gates counting, load_i/sync_i restart a channel and override counting.
module tick_gen #(
    parameter int NCH     = 3,
    parameter int W       = 16,
    parameter int DEF_DIV = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NCH-1:0]   en_i,
    input  logic [NCH-1:0]   oneshot_i,
    input  logic [NCH-1:0]   load_i,
    input  logic [NCH*W-1:0] div_i,
    input  logic             sync_i,
    output logic [NCH-1:0]   tick_o,
    output logic [NCH-1:0]   done_o,
    output logic [NCH-1:0]   square_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);

    state_t         state_q [NCH];
    state_t         state_d [NCH];
    logic [W-1:0]   cnt_q   [NCH];
    logic [W-1:0]   cnt_d   [NCH];
    logic [W-1:0]   divr_q  [NCH];
    logic [W-1:0]   divr_d  [NCH];
    logic [NCH-1:0] tick_d;
    logic [NCH-1:0] done_d;
    logic [NCH-1:0] restart;

    assign restart = load_i | {NCH{sync_i}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
                divr_q[k]  <= DEF_DIV_W;
            end
            tick_o <= '0;
            done_o <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                divr_q[k]  <= divr_d[k];
            end
            tick_o <= tick_d;
            done_o <= done_d;
        end
    end

    // The edge that first samples en_i high already counts, so the first
    // tick lands divr+1 enabled edges after the channel leaves IDLE.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            divr_d[k]  = divr_q[k];
            tick_d[k]  = 1'b0;
            if (restart[k]) begin
                if (load_i[k]) begin
                    divr_d[k] = div_i[k*W +: W];
                end
                cnt_d[k]   = '0;
                state_d[k] = en_i[k] ? ST_RUN : ST_IDLE;
            end else begin
                unique case (state_q[k])
                    ST_IDLE, ST_RUN: begin
                        if (en_i[k]) begin
                            state_d[k] = ST_RUN;
                            if (cnt_q[k] == divr_q[k]) begin
                                cnt_d[k]  = '0;
                                tick_d[k] = 1'b1;
                                if (oneshot_i[k]) begin
                                    state_d[k] = ST_DONE;
                                end
                            end else begin
                                cnt_d[k] = cnt_q[k] + W'(1);
                            end
                        end else begin
                            state_d[k] = ST_IDLE;
                        end
                    end
                    ST_DONE: begin
                        cnt_d[k] = '0;
                    end
                    default: begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = '0;
                    end
                endcase
            end
            done_d[k] = (state_d[k] == ST_DONE);
        end
    end

`ifdef TICK_GEN_SQUARE_EN
    logic [NCH-1:0] sq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sq_q <= '0;
        end else begin
            sq_q <= (sq_q ^ tick_d) & ~restart;
        end
    end

    assign square_o = sq_q;
`else
    assign square_o = '0;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: directed scenarios plus randomized traffic, all checked against a cycle-count reference model.
module tb_tick_gen;

    localparam int NCH     = 3;
    localparam int W       = 8;
    localparam int DEF_DIV = 3;

    logic             clk_i     = 1'b0;
    logic             rst_ni    = 1'b0;
    logic             sync_i    = 1'b0;
    logic [NCH-1:0]   en_i      = '0;
    logic [NCH-1:0]   oneshot_i = '0;
    logic [NCH-1:0]   load_i    = '0;
    logic [NCH*W-1:0] div_i     = '0;
    logic [NCH-1:0]   tick_o;
    logic [NCH-1:0]   done_o;
    logic [NCH-1:0]   square_o;

    int checks   = 0;
    int failures = 0;

    // Reference state: divisor, enabled cycles since last restart, ticks since restart.
    int             m_div   [NCH];
    int             m_el    [NCH];
    int             m_ticks [NCH];
    bit             m_done  [NCH];
    logic [NCH-1:0] m_tick;

    tick_gen #(
        .NCH     (NCH),
        .W       (W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .oneshot_i (oneshot_i),
        .load_i    (load_i),
        .div_i     (div_i),
        .sync_i    (sync_i),
        .tick_o    (tick_o),
        .done_o    (done_o),
        .square_o  (square_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_div[k]   = DEF_DIV;
            m_el[k]    = 0;
            m_ticks[k] = 0;
            m_done[k]  = 1'b0;
        end
        m_tick = '0;
    endtask

    // A tick is due whenever the enabled-cycle count hits the last slot of a divr+1 period.
    task automatic model_edge();
        if (!rst_ni) begin
            model_reset();
        end else begin
            for (int k = 0; k < NCH; k++) begin
                m_tick[k] = 1'b0;
                if (sync_i || load_i[k]) begin
                    if (load_i[k]) m_div[k] = int'(div_i[k*W +: W]);
                    m_el[k]    = 0;
                    m_ticks[k] = 0;
                    m_done[k]  = 1'b0;
                end else if (!m_done[k] && en_i[k]) begin
                    if (m_el[k] % (m_div[k] + 1) == m_div[k]) begin
                        m_tick[k] = 1'b1;
                        m_ticks[k]++;
                        if (oneshot_i[k]) m_done[k] = 1'b1;
                    end
                    m_el[k]++;
                end
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_done();
        logic [NCH-1:0] v;
        for (int k = 0; k < NCH; k++) v[k] = m_done[k];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_square();
        logic [NCH-1:0] v;
        v = '0;
`ifdef TICK_GEN_SQUARE_EN
        for (int k = 0; k < NCH; k++) v[k] = m_ticks[k][0];
`endif
        return v;
    endfunction

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check("tick", 32'(tick_o), 32'(m_tick));
        check("done", 32'(done_o), 32'(exp_done()));
        check("square", 32'(square_o), 32'(exp_square()));
    endtask

    task automatic set_div(input int ch, input int v);
        div_i[ch*W +: W] = W'(v);
    endtask

    task automatic load_ch(input logic [NCH-1:0] mask);
        load_i = mask;
        step();
        load_i = '0;
    endtask

    task automatic run_cnt(input int n, input int ch, output int first, output int cnt);
        first = 0;
        cnt   = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (tick_o[ch]) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
    endtask

    initial begin
        int first;
        int cnt;
        int hi;

        model_reset();
        #1;
        check("rst_tick", 32'(tick_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_square", 32'(square_o), 32'd0);
        step();
        step();
        rst_ni = 1'b1;

        // Periodic, divisor 4 on ch0
        set_div(0, 4);
        load_ch(3'b001);
        en_i = 3'b001;
        run_cnt(15, 0, first, cnt);
        check("div4_first", 32'(first), 32'd5);
        check("div4_count", 32'(cnt), 32'd3);
        check("div4_done", 32'(done_o[0]), 32'd0);
        en_i = '0;
        step();

        // Divisor 0 on ch1: tick every enabled cycle
        set_div(1, 0);
        load_ch(3'b010);
        en_i = 3'b010;
        run_cnt(6, 1, first, cnt);
        check("div0_first", 32'(first), 32'd1);
        check("div0_count", 32'(cnt), 32'd6);
        en_i = '0;
        run_cnt(4, 1, first, cnt);
        check("div0_off", 32'(cnt), 32'd0);

        // One-shot ch2, divisor 9
        set_div(2, 9);
        oneshot_i = 3'b100;
        load_ch(3'b100);
        en_i = 3'b100;
        run_cnt(25, 2, first, cnt);
        check("os_first", 32'(first), 32'd10);
        check("os_count", 32'(cnt), 32'd1);
        check("os_done", 32'(done_o[2]), 32'd1);
        load_ch(3'b100);
        check("os_reload_done", 32'(done_o[2]), 32'd0);
        run_cnt(15, 2, first, cnt);
        check("os_reload_first", 32'(first), 32'd10);
        check("os_done2", 32'(done_o[2]), 32'd1);
        en_i      = '0;
        oneshot_i = '0;

        // Sync restart mid-count
        set_div(0, 7);
        set_div(1, 2);
        load_ch(3'b011);
        en_i = 3'b011;
        step();
        step();
        step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        check("sync_no_tick", 32'(tick_o[0]), 32'd0);
        run_cnt(12, 0, first, cnt);
        check("sync_first", 32'(first), 32'd8);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        run_cnt(9, 1, first, cnt);
        check("sync_ch1_first", 32'(first), 32'd3);
        check("sync_ch1_count", 32'(cnt), 32'd3);

        // Asynchronous reset mid-count (ch2 still reports done)
        step();
        step();
        rst_ni = 1'b0;
        model_reset();
        #1;
        check("arst_tick", 32'(tick_o), 32'd0);
        check("arst_done", 32'(done_o), 32'd0);
        check("arst_square", 32'(square_o), 32'd0);
        step();
        rst_ni = 1'b1;
        en_i   = 3'b001;
        run_cnt(10, 0, first, cnt);
        check("arst_first", 32'(first), 32'(DEF_DIV + 1));

        // Square wave on ch0 with divisor 2
        set_div(0, 2);
        load_ch(3'b001);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (square_o[0]) hi++;
        end
`ifdef TICK_GEN_SQUARE_EN
        check("square_high", 32'(hi), 32'd6);
`else
        check("square_high", 32'(hi), 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NCH; k++) begin
                en_i[k] = ($urandom_range(0, 7) != 0);
                load_i[k] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0) oneshot_i[k] = $urandom_range(0, 1) == 1;
                set_div(k, $urandom_range(0, 7));
            end
            sync_i = ($urandom_range(0, 39) == 0);
            if (!rst_ni) begin
                rst_ni = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                rst_ni = 1'b0;
                model_reset();
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter NCH, default 3, number of independent tick channels (1..8).
REQ-002 Parameter W, default 16, divisor and counter width in bits (2..32).
REQ-003 Parameter DEF_DIV, default 0, reset value of every channel divisor; must be < 2**W.
REQ-004 clk_i  input  1  sole clock; all logic rising-edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 en_i  input  NCH  per-channel count enable.
REQ-007 oneshot_i  input  NCH  per-channel mode; 1 = one-shot, 0 = periodic.
REQ-008 load_i  input  NCH  per-channel divisor load strobe.
REQ-009 div_i  input  NCH*W  divisor values; channel k uses bits [k*W+W-1 : k*W].
REQ-010 sync_i  input  1  global restart of all channels.
REQ-011 tick_o  output  NCH  registered single-cycle tick per channel.
REQ-012 done_o  output  NCH  registered; one-shot channel has fired and halted.
REQ-013 square_o  output  NCH  registered square wave per channel (see Configuration).

Function
REQ-014 Each channel holds divisor register divr[W], counter cnt[W] and state IDLE/RUN/DONE.
REQ-015 Transitions: IDLE->RUN when en_i=1; RUN->IDLE when en_i=0; RUN->DONE on a tick with oneshot_i=1; DONE->RUN on load_i or sync_i with en_i=1, else DONE->IDLE on load_i or sync_i.
REQ-016 IDLE: cnt holds its value; tick_o=0.
REQ-017 RUN: if cnt==divr then cnt<=0 and tick_o=1 in the next cycle, else cnt<=cnt+1 and tick_o=0.
REQ-018 Tick period = divr+1 cycles; divr=0 with en_i held high gives tick_o=1 every cycle.
REQ-019 First tick after RUN entry with cnt=0 appears divr+1 cycles after the first cycle en_i is sampled high.
REQ-020 DONE: cnt holds 0; tick_o=0; done_o=1; en_i changes are ignored.
REQ-021 load_i[k]=1: divr<=div slice k; cnt<=0; done_o[k]<=0; tick_o[k]=0 next cycle regardless of cnt.
REQ-022 sync_i=1: every channel cnt<=0, done_o<=0, tick_o<=0 next cycle; divr is unchanged unless load_i is also high.
REQ-023 Priority per channel: sync_i/load_i > count; simultaneous sync_i and load_i[k] loads divr and zeroes cnt.
REQ-024 oneshot_i is sampled only when a tick is generated; changing it mid-count has no other effect.
REQ-025 Counter arithmetic is modulo 2**W; cnt never exceeds divr except after a load lowers divr, which is impossible because load zeroes cnt.

Reset
REQ-026 rst_ni=0 immediately forces cnt=0, divr=DEF_DIV, state IDLE, tick_o=0, done_o=0, square_o=0.
REQ-027 Release of rst_ni takes effect on the next clk_i edge; counting starts only from en_i=1 sampled after release.
REQ-028 Reset asserted mid-count discards all channel state with no residual tick.

Configuration
REQ-029 Macro TICK_GEN_SQUARE_EN defined: square_o[k] toggles in the same cycle tick_o[k] asserts, is cleared by load_i[k], sync_i or reset, and yields period 2*(divr+1).
REQ-030 Macro TICK_GEN_SQUARE_EN undefined: square_o is a constant 0, no toggle flops are built, and all other behaviour is identical.

Verification
REQ-031 NCH=3, W=8; load div=4 on ch0, en_i=001 -> tick_o[0] pulses every 5 cycles, first 5 cycles after en rises; done_o=0.
REQ-032 div=0 on ch1, en held high for 6 cycles -> tick_o[1]=1 on 6 consecutive cycles; 0 cycles after en_i drops.
REQ-033 ch2 oneshot_i=1, div=9 -> single tick_o[2] after 10 cycles, done_o[2]=1 thereafter; load_i[2] clears done_o and the next tick follows 10 cycles later.
REQ-034 ch0 at cnt=3 of div=7, sync_i pulse -> cnt=0, no tick; next tick 8 cycles after sync; ch1 divisor unchanged.
REQ-035 rst_ni low for 1 cycle mid-count -> all outputs 0 at once, divr=DEF_DIV; with en_i high, a tick follows DEF_DIV+1 cycles after release.
REQ-036 TICK_GEN_SQUARE_EN defined, div=2 -> square_o[0] period 6 cycles, 50% duty; macro undefined -> square_o constant 0.
